// File: rtl/led_trail_fader.sv
// PWM LED driver with comet-trail fade: a lit input LED jumps to full brightness,
// then its level decays linearly on a prescaled tick once the input drops.
module led_trail_fader #(
    parameter int NLED       = 8,
    parameter int PWM_BITS   = 8,
    parameter int DECAY_DIV  = 65536,
    parameter int DECAY_STEP = 16
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic [NLED-1:0] i_led,
    output logic [NLED-1:0] o_led,
    output logic            o_busy
);

    localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(DECAY_STEP);
    localparam int                  DIV_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DECAY_DIV - 1);

    logic [PWM_BITS-1:0] level_reg  [NLED];
    logic [PWM_BITS-1:0] level_next [NLED];
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [DIV_W-1:0]    div_cnt_reg;
    logic [DIV_W-1:0]    div_cnt_next;
    logic [NLED-1:0]     o_led_reg;
    logic [NLED-1:0]     o_led_next;
    logic                o_busy_reg;
    logic                o_busy_next;
    logic [NLED-1:0]     level_nz;
    logic                tick;

    // With DECAY_DIV=1 the counter sits at 0 == DIV_LAST, so tick fires every cycle.
    assign tick         = (div_cnt_reg == DIV_LAST);
    assign div_cnt_next = tick ? '0 : div_cnt_reg + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NLED; gi++) begin : g_led
            // Reload beats decay; decay saturates at zero instead of wrapping.
            assign level_next[gi] = i_led[gi] ? MAX :
                                    !tick     ? level_reg[gi] :
                                    (level_reg[gi] >= STEP) ? level_reg[gi] - STEP :
                                    '0;

            assign o_led_next[gi] = (level_reg[gi] == MAX) | (pwm_cnt_reg < level_reg[gi]);
            assign level_nz[gi]   = (level_reg[gi] != '0);
        end
    endgenerate

    assign o_busy_next = |level_nz;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NLED; i++) begin
                level_reg[i] <= '0;
            end
            pwm_cnt_reg <= '0;
            div_cnt_reg <= '0;
            o_led_reg   <= '0;
            o_busy_reg  <= 1'b0;
        end else begin
            level_reg   <= level_next;
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
            div_cnt_reg <= div_cnt_next;
            o_led_reg   <= o_led_next;
            o_busy_reg  <= o_busy_next;
        end
    end

    assign o_led  = o_led_reg;
    assign o_busy = o_busy_reg;

endmodule

// File: tb/tb_led_trail_fader.sv
// Directed bench for led_trail_fader: fast-decay instance for trail/priority tests,
// slow-decay instance to hold a mid level steady across a full PWM window.
module tb_led_trail_fader;

    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic [7:0] i_led;
    logic [7:0] o_led;
    logic       o_busy;
    logic [7:0] hold_led;
    logic [7:0] hold_o_led;
    logic       hold_o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    led_trail_fader #(
        .NLED(8), .PWM_BITS(8), .DECAY_DIV(4), .DECAY_STEP(64)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_led     (i_led),
        .o_led     (o_led),
        .o_busy    (o_busy)
    );

    // Slow decay so that level 127 stays put for a whole 256-cycle PWM window.
    led_trail_fader #(
        .NLED(8), .PWM_BITS(8), .DECAY_DIV(1024), .DECAY_STEP(128)
    ) u_hold (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_led     (hold_led),
        .o_led     (hold_o_led),
        .o_busy    (hold_o_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: got %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // Returns at a negedge with reset just released; the next posedge is edge 1.
    task automatic reset_dut();
        @(negedge i_clk);
        i_reset_n = 1'b0;
        i_led     = '0;
        hold_led  = '0;
        steps(2);
        i_reset_n = 1'b1;
    endtask

    initial begin
        int hi7, good_cnt, busy_cnt, hi3, bad, all_zero;
        logic [7:0] lv, prev [8];

        i_reset_n = 1'b1;
        i_led     = '0;
        hold_led  = '0;

        // Power-up reset, asserted before any clock edge
        #2 i_reset_n = 1'b0;
        #1;
        check("reset o_led", o_led, 0);
        check("reset o_busy", o_busy, 0);
        reset_dut();

        // Single-cycle pulse on LED0 and its fade
        i_led = 8'h01;
        step();
        check("t2 e1 level0", dut.level_reg[0], 255);
        check("t2 e1 o_led", o_led, 0);
        check("t2 e1 busy", o_busy, 0);
        i_led = 8'h00;
        step();
        check("t2 e2 o_led", o_led, 8'h01);
        check("t2 e2 busy", o_busy, 1);
        steps(2);
        check("t2 e4 level0", dut.level_reg[0], 191);
        steps(4);
        check("t2 e8 level0", dut.level_reg[0], 127);
        steps(4);
        check("t2 e12 level0", dut.level_reg[0], 63);
        check("t2 e12 o_led", o_led, 8'h01);
        steps(4);
        check("t2 e16 level0", dut.level_reg[0], 0);
        check("t2 e16 busy", o_busy, 1);
        step();
        check("t2 e17 busy", o_busy, 0);
        check("t2 e17 o_led", o_led, 0);

        // Reload coincides with a tick: LED5 reloads, LED4 saturates to 0
        reset_dut();
        i_led = 8'h30;
        step();
        i_led = 8'h00;
        steps(14);
        check("t4 e15 level5", dut.level_reg[5], 63);
        check("t4 e15 level4", dut.level_reg[4], 63);
        i_led = 8'h20;
        step();
        check("t4 e16 level5", dut.level_reg[5], 255);
        check("t4 e16 level4", dut.level_reg[4], 0);
        i_led = 8'h00;

        // Two LEDs held: constantly on, others dark, busy throughout
        reset_dut();
        i_led = 8'h81;
        steps(2);
        hi7 = 0; good_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            hi7      += int'(o_led[7]);
            good_cnt += int'(o_led == 8'h81);
            busy_cnt += int'(o_busy);
            step();
        end
        check("t5 o_led==81 cycles", good_cnt, 256);
        check("t5 busy cycles", busy_cnt, 256);
        check("t3 level255 high of 256", hi7, 256);

        // Asynchronous reset in the middle of a cycle while LEDs are lit
        @(posedge i_clk);
        #3 i_reset_n = 1'b0;
        #1;
        check("t1 async o_led", o_led, 0);
        check("t1 async busy", o_busy, 0);
        @(negedge i_clk);
        i_led = 8'h00;
        step();
        i_reset_n = 1'b1;
        step();
        all_zero = 1;
        for (int i = 0; i < 8; i++) if (dut.level_reg[i] != 8'd0) all_zero = 0;
        check("t1 levels zero after release", all_zero, 1);
        check("t1 o_led after release", o_led, 0);
        check("t1 busy after release", o_busy, 0);

        // Level 127 held over one full PWM window
        reset_dut();
        hold_led = 8'h08;
        step();
        hold_led = 8'h00;
        steps(1029);
        check("t3 hold level3", u_hold.level_reg[3], 127);
        hi3 = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            hi3 += int'(hold_o_led[3]);
        end
        check("t3 level127 high of 256", hi3, 127);
        check("t3 hold level3 after window", u_hold.level_reg[3], 127);

        // Walker-driven sweep: one-hot shifting every 16 clocks
        reset_dut();
        bad = 0;
        for (int i = 0; i < 8; i++) prev[i] = 8'd0;
        for (int s = 0; s < 24; s++) begin
            i_led = 8'h01 << (s % 8);
            for (int c = 0; c < 16; c++) begin
                step();
                for (int i = 0; i < 8; i++) begin
                    lv = dut.level_reg[i];
                    if (!(lv == 8'd0 || lv == 8'd63 || lv == 8'd127 || lv == 8'd191 || lv == 8'd255))
                        bad++;
                    if (lv > prev[i] && lv != 8'd255)
                        bad++;
                    prev[i] = lv;
                end
            end
            check($sformatf("t6 slot%0d active level", s), dut.level_reg[s % 8], 255);
        end
        check("t6 illegal level observations", bad, 0);
        i_led = 8'h00;
        steps(20);
        check("t6 busy after drain", o_busy, 0);
        check("t6 o_led after drain", o_led, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
